// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator control blocks: scheduler state
// encoding, job field width and the per-group channel count helper.
package accel_pkg;

    localparam int PE_OC_DEFAULT = 8;
    localparam int JOB_W         = 8;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t ST_IDLE   = 3'd0;
    localparam sched_state_t ST_LOAD_W = 3'd1;
    localparam sched_state_t ST_ISSUE  = 3'd2;
    localparam sched_state_t ST_DRAIN  = 3'd3;
    localparam sched_state_t ST_DONE   = 3'd4;

    // Channels in the group starting at oc_base, evaluated at 9 bits so the
    // subtraction cannot wrap.
    function automatic logic [JOB_W-1:0] group_cnt(
        input logic [JOB_W-1:0] out_ch,
        input logic [JOB_W-1:0] oc_base,
        input logic [JOB_W:0]   pe_oc
    );
        logic [JOB_W:0] rem;
        rem = {1'b0, out_ch} - {1'b0, oc_base};
        if (oc_base >= out_ch) return '0;
        if (rem > pe_oc) return pe_oc[JOB_W-1:0];
        return rem[JOB_W-1:0];
    endfunction

endpackage

// File: rtl/job_credit_counter.sv
// In-flight job counter: +1 per issued job, -1 per completion, with the
// credit-limit compare and an underflow flag for completions with none pending.
module job_credit_counter #(
    parameter int MAX_OUT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] count,
    output logic       below_limit,
    output logic       drained_next,
    output logic       underflow
);

    localparam logic [3:0] LIMIT = 4'(MAX_OUT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = dec && !inc && (cnt_q == 4'd0);
        if (inc && !dec) begin
            cnt_d = cnt_q + 4'd1;
        end else if (dec && !inc && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count        = cnt_q;
    assign below_limit  = cnt_q < LIMIT;
    assign drained_next = cnt_d == 4'd0;

endmodule

// File: rtl/pw_tile_scheduler.sv
// Pointwise-convolution layer sequencer: per output-channel group, load the
// weights, then issue one row-tile job per feature-map row under a credit limit.
module pw_tile_scheduler
    import accel_pkg::*;
#(
    parameter int PE_OC   = PE_OC_DEFAULT,
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       cfg_size,
    input  logic [7:0]       cfg_in_ch,
    input  logic [7:0]       cfg_out_ch,
    output logic             wload_req,
    output logic [7:0]       wload_oc_base,
    input  logic             wload_done,
    output logic             job_valid,
    input  logic             job_ready,
    output logic [7:0]       job_row,
    output logic [7:0]       job_oc_base,
    output logic [7:0]       job_oc_cnt,
    output logic [7:0]       job_in_ch,
    output logic [7:0]       job_size,
    input  logic             tile_done,
    output logic             busy,
    output logic             done,
    output logic [3:0]       outstanding,
    output logic [CNT_W-1:0] tile_count,
    output logic             protocol_err
);

    localparam logic [JOB_W:0] PE_OC_W = (JOB_W+1)'(PE_OC);

    sched_state_t     state_q, state_d;
    logic [7:0]       size_q, size_d;
    logic [7:0]       in_ch_q, in_ch_d;
    logic [7:0]       out_ch_q, out_ch_d;
    logic [7:0]       oc_base_q, oc_base_d;
    logic [7:0]       row_q, row_d;
    logic [CNT_W-1:0] tile_cnt_q, tile_cnt_d;
    logic             err_q, err_d;
    logic             wload_req_q, wload_req_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             fire;
    logic             below_limit;
    logic             drained_next;
    logic             underflow;
    logic             start_acc;
    logic             cfg_zero;
    logic             last_row;
    logic             group_last;
    logic [8:0]       next_base;

    job_credit_counter #(
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc          (fire),
        .dec          (tile_done),
        .count        (outstanding),
        .below_limit  (below_limit),
        .drained_next (drained_next),
        .underflow    (underflow)
    );

    // Valid depends only on registered state, so a raised offer can only be
    // retired by its own fire (completions only ever free credits).
    assign job_valid  = (state_q == ST_ISSUE) && below_limit;
    assign fire       = job_valid && job_ready;
    assign start_acc  = (state_q == ST_IDLE) && start;
    assign cfg_zero   = (cfg_size == 8'd0) || (cfg_in_ch == 8'd0) || (cfg_out_ch == 8'd0);
    assign last_row   = row_q == (size_q - 8'd1);
    assign next_base  = {1'b0, oc_base_q} + PE_OC_W;
    assign group_last = next_base >= {1'b0, out_ch_q};

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        in_ch_d    = in_ch_q;
        out_ch_d   = out_ch_q;
        oc_base_d  = oc_base_q;
        row_d      = row_q;
        tile_cnt_d = tile_cnt_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_d     = cfg_size;
                    in_ch_d    = cfg_in_ch;
                    out_ch_d   = cfg_out_ch;
                    oc_base_d  = 8'd0;
                    row_d      = 8'd0;
                    tile_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = cfg_zero ? ST_DONE : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (wload_done) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (fire) begin
                    if (tile_cnt_q != '1) tile_cnt_d = tile_cnt_q + CNT_W'(1);
                    if (last_row) begin
                        row_d   = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        row_d = row_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // Weights are single-buffered: the next group waits for every tile.
                if (drained_next) begin
                    if (group_last) begin
                        state_d = ST_DONE;
                    end else begin
                        oc_base_d = next_base[7:0];
                        state_d   = ST_LOAD_W;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (underflow || (wload_done && (state_q != ST_LOAD_W))) err_d = 1'b1;

        wload_req_d = (state_q == ST_LOAD_W) && !wload_done;
        done_d      = state_q == ST_DONE;
        busy_d      = (state_d != ST_IDLE) || (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            size_q      <= 8'd0;
            in_ch_q     <= 8'd0;
            out_ch_q    <= 8'd0;
            oc_base_q   <= 8'd0;
            row_q       <= 8'd0;
            tile_cnt_q  <= '0;
            err_q       <= 1'b0;
            wload_req_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            in_ch_q     <= in_ch_d;
            out_ch_q    <= out_ch_d;
            oc_base_q   <= oc_base_d;
            row_q       <= row_d;
            tile_cnt_q  <= tile_cnt_d;
            err_q       <= err_d;
            wload_req_q <= wload_req_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign wload_req     = wload_req_q;
    assign wload_oc_base = oc_base_q;
    assign job_row       = row_q;
    assign job_oc_base   = oc_base_q;
    assign job_oc_cnt    = group_cnt(out_ch_q, oc_base_q, PE_OC_W);
    assign job_in_ch     = in_ch_q;
    assign job_size      = size_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign tile_count    = tile_cnt_q;
    assign protocol_err  = err_q;

endmodule
